ob_drain_ctrl: RTL
==================

# ob_drain_ctrl

Read-side controller for the output buffer. It pulls finished result rows out of the output buffer and streams them to the downstream writeback path. On a start command it reads rows in groups of four through the buffer's four read address ports (add_1..add_4 → out1..out4). It captures each group and emits it one row per beat on a valid/ready stream. It is the drain counterpart to the PE array that fills the buffer through Wr_ctrl/add_in/in.

## Interface
- data_width, default 8: bits per lane element.
- width, default 4: lanes per row; must match output buffer.
- depth, default 32: rows per lane; address width is $clog2(depth) = 5.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  in  5  first row to read.
- num_rows  in  6  rows to read; 0 allowed, values > depth are treated as depth.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion.
- add_1..add_4  out  [width-1:0][4:0]  read addresses to output buffer; all lanes carry the same address.
- out1..out4  in  [width-1:0][data_width-1:0]  buffer read data.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  width*data_width  one row; lane i at bits [i*data_width +: data_width].
- m_last  out  1  high on the final beat of a command.

## Operation
- FSM states: IDLE, READ, WAIT, SEND, FIN.
- IDLE → READ on start with clamped num_rows ≠ 0. On start with num_rows = 0: IDLE → FIN. In both cases base_addr and the clamped count are latched.
- READ, one cycle: add_k = (ptr + k−1) mod depth for k = 1..4 on every lane, where ptr is the current row pointer.
- WAIT, one cycle: the buffer read latency is 1 cycle. At the end of WAIT, out1..out4 are registered into a 4-row holding register. grp_n = min(4, remaining).
- SEND: rows 0..grp_n−1 of the holding register are presented in order. A beat advances on m_valid && m_ready.
  - After the last beat of a group: ptr += grp_n (mod depth) and remaining −= grp_n.
  - Then go to READ if remaining > 0, else FIN.
- FIN, one cycle: done = 1, busy = 0 on the following cycle, then return to IDLE.
- In a partial final group, address slots ≥ grp_n still drive ptr+k−1 mod depth. Their data is discarded.
- start while not IDLE is ignored.
- m_last = 1 on the beat where remaining == 1.
- Address pointer arithmetic is 5-bit unsigned and wraps 31 → 0.
- add_* hold their last value outside READ/WAIT.
- Reset values: busy 0, done 0, m_valid 0, m_last 0, m_data 0, all add_* 0, FSM IDLE, counters 0.
- rst asserted in any state takes effect immediately and asynchronously. Any in-flight stream is abandoned with no m_last and no done.

## Timing
- Start sampled at edge 0: READ in cycle 1, WAIT in cycle 2, first m_valid in cycle 3.
- With m_ready held high, each group costs 2 + grp_n cycles.
- Total drain time for N rows is 2·ceil(N/4) + N cycles plus 1 FIN cycle.
- done is asserted in the cycle after the final handshake.
- While m_valid && !m_ready: m_data, m_last and m_valid are held stable. m_valid never drops without a handshake.
- m_valid is low during READ, WAIT and FIN; there are no bubbles inside a group.
- num_rows = 0: done pulses in cycle 1 and m_valid never asserts.

## Test plan
The bench uses a behavioral buffer model with 1-cycle read latency, where lane i at address a holds (4a + i) mod 256.
- base 0, num 4, m_ready = 1 → add_1..4 = 0,1,2,3. Beats rows 0..3, row r lane i = 4r+i. m_valid in cycles 3–6, m_last in cycle 6, done in cycle 7.
- Wrap: base 30, num 5 → group 1 addresses 30,31,0,1. Group 2 add_1 = 2. Beat data lane 0 = 120, 124, 0, 4, 8. m_last on the 5th beat.
- Backpressure: base 4, num 4, m_ready = 1010… → each beat holds m_data stable while m_ready = 0. Exactly 4 handshakes with values 16+i, 20+i, 24+i, 28+i.
- Edge counts:
  - num 0 → done in cycle 1, no m_valid.
  - num 40 → exactly 32 beats, rows base..base+31 mod 32.
- Reset mid-SEND: assert rst on the 2nd beat of num 8 → all outputs 0 immediately and busy 0. A new start (base 8, num 1) yields a single beat of 32+i with m_last.
- A start pulse with base 0 issued during busy leaves the running command's addresses, data and beat count unchanged.

Source files
------------

// File: rtl/ob_drain_if.sv
// Bundle between the output-buffer drain controller, the buffer read ports and the writeback stream.
// The master side is the controller, which drives addresses, status and the stream.
interface ob_drain_if #(
   parameter int data_width = 8,
   parameter int width      = 4,
   parameter int depth      = 32
);
   localparam int AW = $clog2(depth);
   localparam int CW = $clog2(depth + 1);

   logic                                  start;
   logic [AW-1:0]                         base_addr;
   logic [CW-1:0]                         num_rows;
   logic                                  busy;
   logic                                  done;
   logic [width-1:0][AW-1:0]              add_1;
   logic [width-1:0][AW-1:0]              add_2;
   logic [width-1:0][AW-1:0]              add_3;
   logic [width-1:0][AW-1:0]              add_4;
   logic [width-1:0][data_width-1:0]      out1;
   logic [width-1:0][data_width-1:0]      out2;
   logic [width-1:0][data_width-1:0]      out3;
   logic [width-1:0][data_width-1:0]      out4;
   logic                                  m_valid;
   logic                                  m_ready;
   logic [width*data_width-1:0]           m_data;
   logic                                  m_last;

   modport master (
      input  start, base_addr, num_rows,
      input  out1, out2, out3, out4,
      input  m_ready,
      output busy, done,
      output add_1, add_2, add_3, add_4,
      output m_valid, m_data, m_last
   );

   modport slave (
      output start, base_addr, num_rows,
      output out1, out2, out3, out4,
      output m_ready,
      input  busy, done,
      input  add_1, add_2, add_3, add_4,
      input  m_valid, m_data, m_last
   );
endinterface

// File: rtl/ob_drain_ctrl.sv
// Drains result rows from the output buffer four at a time and streams them one row per beat.
// Each group is read, captured after the buffer's one-cycle latency, then emitted on valid/ready.
module ob_drain_ctrl #(
   parameter int data_width = 8,
   parameter int width      = 4,
   parameter int depth      = 32
) (
   input  logic          clk,
   input  logic          rst,
   ob_drain_if.master    bus
);
   localparam int AW = $clog2(depth);
   localparam int CW = $clog2(depth + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(depth);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      SEND,
      FIN
   } state_t;

   typedef logic [width-1:0][data_width-1:0] row_t;

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] rem_q, rem_d;
   logic [2:0]    grp_q, grp_d;
   logic [1:0]    beat_q, beat_d;
   logic [AW-1:0] addr_q [4];
   row_t          hold_q [4];
   logic          loadAddr;
   logic          beatLast;
   logic [CW-1:0] numClamped;

   function automatic logic [AW-1:0] wrapAdd(input logic [AW-1:0] a, input logic [CW-1:0] b);
      int s;
      s = int'(a) + int'(b);
      if (s >= depth) s = s - depth;
      return AW'(s);
   endfunction

   assign numClamped = (bus.num_rows > DEPTH_C) ? DEPTH_C : bus.num_rows;
   assign beatLast   = ({1'b0, beat_q} == (grp_q - 3'd1));

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      rem_d    = rem_q;
      grp_d    = grp_q;
      beat_d   = beat_q;
      loadAddr = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               ptr_d  = bus.base_addr;
               rem_d  = numClamped;
               beat_d = 2'd0;
               if (numClamped != '0) begin
                  state_d  = READ;
                  loadAddr = 1'b1;
               end else begin
                  state_d = FIN;
               end
            end
         end
         READ: state_d = WAIT;
         WAIT: begin
            grp_d   = (rem_q >= CW'(4)) ? 3'd4 : rem_q[2:0];
            beat_d  = 2'd0;
            state_d = SEND;
         end
         SEND: begin
            if (bus.m_ready) begin
               if (beatLast) begin
                  ptr_d  = wrapAdd(ptr_q, CW'(grp_q));
                  rem_d  = rem_q - CW'(grp_q);
                  beat_d = 2'd0;
                  if (rem_d != '0) begin
                     state_d  = READ;
                     loadAddr = 1'b1;
                  end else begin
                     state_d = FIN;
                  end
               end else begin
                  beat_d = beat_q + 2'd1;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         grp_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         grp_q   <= grp_d;
         beat_q  <= beat_d;
      end
   end

   // Slot addresses are registered so they stay put through WAIT and hold afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) addr_q[k] <= '0;
      end else if (loadAddr) begin
         for (int k = 0; k < 4; k++) addr_q[k] <= wrapAdd(ptr_d, CW'(k));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) hold_q[k] <= '0;
      end else if (state_q == WAIT) begin
         hold_q[0] <= bus.out1;
         hold_q[1] <= bus.out2;
         hold_q[2] <= bus.out3;
         hold_q[3] <= bus.out4;
      end
   end

   assign bus.add_1   = {width{addr_q[0]}};
   assign bus.add_2   = {width{addr_q[1]}};
   assign bus.add_3   = {width{addr_q[2]}};
   assign bus.add_4   = {width{addr_q[3]}};

   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == FIN);
   assign bus.m_valid = (state_q == SEND);
   assign bus.m_data  = bus.m_valid ? hold_q[beat_q] : '0;
   // The last beat of the command is the last beat of the final group.
   assign bus.m_last  = bus.m_valid && beatLast && (rem_q == CW'(grp_q));
endmodule
